// File: rtl/banked_regfile.sv
// banked_regfile: DEPTH x DATA_WIDTH register file with four access paths.
//   - sequential write port (auto-incrementing pointer, wrap pulse)
//   - random write port (explicit address, range checked)
//   - sequential read port (auto-incrementing pointer, wrap pulse)
//   - random read port (explicit address, range checked)
// Reads are registered (1-cycle latency). Random write wins a write collision.
// Reset clears pointers and outputs only; memory contents survive reset.
// Optional build macro REGFILE_RDW_BYPASS_EN: a read of an address written in
// the same cycle returns the new data. Without it the old contents are returned.
module banked_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seq_we,
    input  logic [DATA_WIDTH-1:0] seq_w_data,
    input  logic                  seq_w_clr,
    input  logic                  ran_we,
    input  logic [ADDR_WIDTH-1:0] ran_w_addr,
    input  logic [DATA_WIDTH-1:0] ran_w_data,
    input  logic                  seq_re,
    input  logic                  seq_r_clr,
    output logic [DATA_WIDTH-1:0] seq_r_data,
    output logic                  seq_r_valid,
    output logic [ADDR_WIDTH-1:0] out_seq_r_addr,
    input  logic                  ran_re,
    input  logic [ADDR_WIDTH-1:0] ran_r_addr,
    output logic [DATA_WIDTH-1:0] ran_r_data,
    output logic                  ran_r_valid,
    output logic [ADDR_WIDTH-1:0] out_ran_r_addr,
    output logic                  seq_w_wrap,
    output logic                  seq_r_wrap,
    output logic                  wr_collision,
    output logic                  addr_err
);

    // Index width covers exactly DEPTH entries; addresses are range checked
    // before use, so the upper address bits are zero whenever we index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] seq_r_data_q, ran_r_data_q;
    logic [ADDR_WIDTH-1:0] seq_r_addr_q, ran_r_addr_q;
    logic                  seq_r_valid_q, ran_r_valid_q;
    logic                  seq_w_wrap_q, seq_r_wrap_q;
    logic                  wr_collision_q, addr_err_q;

    logic [ADDR_WIDTH-1:0] seq_w_addr, seq_r_addr;
    logic                  ran_w_in, ran_r_in;
    logic                  ran_w_ok, ran_r_ok;
    logic                  collision;
    logic [DATA_WIDTH-1:0] seq_rd_word, ran_rd_word;

    // Effective addresses, range checks, collision detect and pointer next-state.
    always_comb begin
        seq_w_addr = seq_w_clr ? '0 : wptr_q;
        seq_r_addr = seq_r_clr ? '0 : rptr_q;
        ran_w_in   = ({1'b0, ran_w_addr} < DEPTH_C);
        ran_r_in   = ({1'b0, ran_r_addr} < DEPTH_C);
        ran_w_ok   = ran_we && ran_w_in;
        ran_r_ok   = ran_re && ran_r_in;
        collision  = seq_we && ran_w_ok && (seq_w_addr == ran_w_addr);

        wptr_d = seq_w_addr;
        if (seq_we) begin
            wptr_d = (seq_w_addr == LAST_C) ? '0 : seq_w_addr + ADDR_WIDTH'(1);
        end
        rptr_d = seq_r_addr;
        if (seq_re) begin
            rptr_d = (seq_r_addr == LAST_C) ? '0 : seq_r_addr + ADDR_WIDTH'(1);
        end
    end

    // Read word selection; with bypass, the random write takes priority so a
    // collision forwards the same data that actually lands in memory.
    always_comb begin
        seq_rd_word = mem_q[seq_r_addr[IDX_W-1:0]];
        ran_rd_word = mem_q[ran_r_addr[IDX_W-1:0]];
`ifdef REGFILE_RDW_BYPASS_EN
        if (ran_w_ok && (ran_w_addr == seq_r_addr)) begin
            seq_rd_word = ran_w_data;
        end else if (seq_we && (seq_w_addr == seq_r_addr)) begin
            seq_rd_word = seq_w_data;
        end
        if (ran_w_ok && (ran_w_addr == ran_r_addr)) begin
            ran_rd_word = ran_w_data;
        end else if (seq_we && (seq_w_addr == ran_r_addr)) begin
            ran_rd_word = seq_w_data;
        end
`endif
    end

    // Memory array: no reset, writes blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (seq_we && !collision) begin
                mem_q[seq_w_addr[IDX_W-1:0]] <= seq_w_data;
            end
            if (ran_w_ok) begin
                mem_q[ran_w_addr[IDX_W-1:0]] <= ran_w_data;
            end
        end
    end

    // Pointers, registered read outputs and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            seq_r_data_q   <= '0;
            seq_r_addr_q   <= '0;
            seq_r_valid_q  <= 1'b0;
            ran_r_data_q   <= '0;
            ran_r_addr_q   <= '0;
            ran_r_valid_q  <= 1'b0;
            seq_w_wrap_q   <= 1'b0;
            seq_r_wrap_q   <= 1'b0;
            wr_collision_q <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            seq_w_wrap_q   <= seq_we && (seq_w_addr == LAST_C);
            seq_r_wrap_q   <= seq_re && (seq_r_addr == LAST_C);
            wr_collision_q <= collision;
            addr_err_q     <= (ran_we && !ran_w_in) || (ran_re && !ran_r_in);
            seq_r_valid_q  <= seq_re;
            ran_r_valid_q  <= ran_r_ok;
            if (seq_re) begin
                seq_r_data_q <= seq_rd_word;
                seq_r_addr_q <= seq_r_addr;
            end
            if (ran_r_ok) begin
                ran_r_data_q <= ran_rd_word;
                ran_r_addr_q <= ran_r_addr;
            end
        end
    end

    assign seq_r_data     = seq_r_data_q;
    assign seq_r_valid    = seq_r_valid_q;
    assign out_seq_r_addr = seq_r_addr_q;
    assign ran_r_data     = ran_r_data_q;
    assign ran_r_valid    = ran_r_valid_q;
    assign out_ran_r_addr = ran_r_addr_q;
    assign seq_w_wrap     = seq_w_wrap_q;
    assign seq_r_wrap     = seq_r_wrap_q;
    assign wr_collision   = wr_collision_q;
    assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_banked_regfile.sv
// Testbench for banked_regfile (DEPTH=8, ADDR_WIDTH=4, DATA_WIDTH=8).
// Table of {inputs, expected outputs}; the expected record is queued when the
// inputs are driven and popped/compared one clock later.
module tb_banked_regfile;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DP = 8;

`ifdef REGFILE_RDW_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic          rst;
        logic          swe;
        logic [DW-1:0] swd;
        logic          swc;
        logic          rwe;
        logic [AW-1:0] rwa;
        logic [DW-1:0] rwd;
        logic          sre;
        logic          src;
        logic          rre;
        logic [AW-1:0] rra;
    } in_t;

    typedef struct packed {
        logic [DW-1:0] srd;
        logic          srv;
        logic [AW-1:0] sra;
        logic [DW-1:0] rrd;
        logic          rrv;
        logic [AW-1:0] rra;
        logic          sww;
        logic          srw;
        logic          col;
        logic          aerr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          seq_we = 1'b0;
    logic [DW-1:0] seq_w_data = '0;
    logic          seq_w_clr = 1'b0;
    logic          ran_we = 1'b0;
    logic [AW-1:0] ran_w_addr = '0;
    logic [DW-1:0] ran_w_data = '0;
    logic          seq_re = 1'b0;
    logic          seq_r_clr = 1'b0;
    logic [DW-1:0] seq_r_data;
    logic          seq_r_valid;
    logic [AW-1:0] out_seq_r_addr;
    logic          ran_re = 1'b0;
    logic [AW-1:0] ran_r_addr = '0;
    logic [DW-1:0] ran_r_data;
    logic          ran_r_valid;
    logic [AW-1:0] out_ran_r_addr;
    logic          seq_w_wrap, seq_r_wrap, wr_collision, addr_err;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    always #5 clk = ~clk;

    banked_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .seq_we(seq_we), .seq_w_data(seq_w_data), .seq_w_clr(seq_w_clr),
        .ran_we(ran_we), .ran_w_addr(ran_w_addr), .ran_w_data(ran_w_data),
        .seq_re(seq_re), .seq_r_clr(seq_r_clr),
        .seq_r_data(seq_r_data), .seq_r_valid(seq_r_valid), .out_seq_r_addr(out_seq_r_addr),
        .ran_re(ran_re), .ran_r_addr(ran_r_addr),
        .ran_r_data(ran_r_data), .ran_r_valid(ran_r_valid), .out_ran_r_addr(out_ran_r_addr),
        .seq_w_wrap(seq_w_wrap), .seq_r_wrap(seq_r_wrap),
        .wr_collision(wr_collision), .addr_err(addr_err)
    );

    function automatic void add(in_t i, out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endfunction

    task automatic drive(input in_t i);
        rst        = i.rst;
        seq_we     = i.swe;
        seq_w_data = i.swd;
        seq_w_clr  = i.swc;
        ran_we     = i.rwe;
        ran_w_addr = i.rwa;
        ran_w_data = i.rwd;
        seq_re     = i.sre;
        seq_r_clr  = i.src;
        ran_re     = i.rre;
        ran_r_addr = i.rra;
    endtask

    function automatic out_t sample();
        out_t a;
        a.srd  = seq_r_data;
        a.srv  = seq_r_valid;
        a.sra  = out_seq_r_addr;
        a.rrd  = ran_r_data;
        a.rrv  = ran_r_valid;
        a.rra  = out_ran_r_addr;
        a.sww  = seq_w_wrap;
        a.srw  = seq_r_wrap;
        a.col  = wr_collision;
        a.aerr = addr_err;
        return a;
    endfunction

    task automatic check_vec(input int idx);
        out_t a;
        out_t e;
        a = sample();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL vec%0d: scoreboard empty, got %h", idx, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL vec%0d: got srd=%h srv=%b sra=%0d rrd=%h rrv=%b rra=%0d sww=%b srw=%b col=%b aerr=%b | want srd=%h srv=%b sra=%0d rrd=%h rrv=%b rra=%0d sww=%b srw=%b col=%b aerr=%b",
                         idx, a.srd, a.srv, a.sra, a.rrd, a.rrv, a.rra, a.sww, a.srw, a.col, a.aerr,
                         e.srd, e.srv, e.sra, e.rrd, e.rrv, e.rra, e.sww, e.srw, e.col, e.aerr);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [DW-1:0] b16, b19, b35;
        in_t  idle;
        int   wraps;
        int   wrap_at;

        b16 = BYP ? 8'hA1 : 8'h66;
        b19 = BYP ? 8'h77 : 8'hA1;
        b35 = BYP ? 8'hD2 : 8'h3F;
        idle = '0;

        //   in:  rst  swe  swd    swc  rwe  rwa   rwd    sre  src  rre  rra
        //   out: srd  srv sra   rrd  rrv rra   sww  srw  col  aerr
        add('{1'b1,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h00,1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b1,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h00,1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'hF3,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h00,1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h98,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h00,1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h3F,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h00,1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'hF3,1'b1,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'h98,1'b1,4'd1,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'h3F,1'b1,4'd2,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h3F,1'b0,4'd2,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h11,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h3F,1'b0,4'd2,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h22,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h3F,1'b0,4'd2,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h55,1'b0,1'b1,4'd5,8'hA0,1'b0,1'b0,1'b0,4'd0}, '{8'h3F,1'b0,4'd2,8'h00,1'b0,4'd0,1'b0,1'b0,1'b1,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h3F,1'b0,4'd2,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd5}, '{8'h3F,1'b0,4'd2,8'hA0,1'b1,4'd5,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'h11,1'b1,4'd3,8'hA0,1'b0,4'd5,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b1,4'd6,8'h66,1'b0,1'b0,1'b0,4'd0}, '{8'h11,1'b0,4'd3,8'hA0,1'b0,4'd5,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b1,4'd6,8'hA1,1'b0,1'b0,1'b1,4'd6}, '{8'h11,1'b0,4'd3,b16  ,1'b1,4'd6,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd6}, '{8'h11,1'b0,4'd3,8'hA1,1'b1,4'd6,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b1,4'd3}, '{8'h22,1'b1,4'd4,8'h11,1'b1,4'd3,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h77,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd6}, '{8'h22,1'b0,4'd4,b19  ,1'b1,4'd6,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd9}, '{8'h22,1'b0,4'd4,b19  ,1'b0,4'd6,1'b0,1'b0,1'b0,1'b1});
        add('{1'b0,1'b0,8'h00,1'b0,1'b1,4'd12,8'hEE,1'b0,1'b0,1'b0,4'd0},'{8'h22,1'b0,4'd4,b19  ,1'b0,4'd6,1'b0,1'b0,1'b0,1'b1});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd4}, '{8'h22,1'b0,4'd4,8'h22,1'b1,4'd4,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h88,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h22,1'b0,4'd4,8'h22,1'b0,4'd4,1'b1,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'h99,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h22,1'b0,4'd4,8'h22,1'b0,4'd4,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd0}, '{8'h22,1'b0,4'd4,8'h99,1'b1,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'hA0,1'b1,4'd5,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'h77,1'b1,4'd6,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'h88,1'b1,4'd7,8'h99,1'b0,4'd0,1'b0,1'b1,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b0,4'd0}, '{8'h99,1'b1,4'd0,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'h98,1'b1,4'd1,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'hC0,1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h98,1'b0,4'd1,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'hC1,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'h98,1'b0,4'd1,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b1,1'b0,4'd0}, '{8'hC0,1'b1,4'd0,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b0,4'd0}, '{8'hC1,1'b1,4'd1,8'h99,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'hD0,1'b0,1'b1,4'd2,8'hD2,1'b1,1'b0,1'b1,4'd2}, '{b35  ,1'b1,4'd2,b35  ,1'b1,4'd2,1'b0,1'b0,1'b1,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd2}, '{b35  ,1'b0,4'd2,8'hD2,1'b1,4'd2,1'b0,1'b0,1'b0,1'b0});
        add('{1'b1,1'b1,8'hE7,1'b0,1'b1,4'd3,8'hE8,1'b1,1'b0,1'b1,4'd3}, '{8'h00,1'b0,4'd0,8'h00,1'b0,4'd0,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b1,1'b0,1'b1,4'd3}, '{8'hC0,1'b1,4'd0,8'h11,1'b1,4'd3,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b1,8'hF0,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b0,4'd0}, '{8'hC0,1'b0,4'd0,8'h11,1'b0,4'd3,1'b0,1'b0,1'b0,1'b0});
        add('{1'b0,1'b0,8'h00,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,4'd0}, '{8'hC0,1'b0,4'd0,8'hF0,1'b1,4'd0,1'b0,1'b0,1'b0,1'b0});

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            exp_q.push_back(vecs[k].o);
            @(posedge clk);
            #1;
            check_vec(k);
        end

        // Wrap sequence: reset, then DP+2 sequential writes; exactly one
        // wrap pulse, right after the DP-th write, and writes DP+1, DP+2
        // land at addresses 0 and 1.
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_wptr_wrap_low", 32'(seq_w_wrap), 32'd0);
        wraps   = 0;
        wrap_at = -1;
        for (int k = 0; k < DP + 2; k++) begin
            @(negedge clk);
            drive(idle);
            seq_we     = 1'b1;
            seq_w_data = 8'h40 + 8'(k);
            @(posedge clk);
            #1;
            if (seq_w_wrap === 1'b1) begin
                wraps++;
                wrap_at = k;
            end
        end
        @(negedge clk);
        drive(idle);
        ran_re     = 1'b1;
        ran_r_addr = 4'd0;
        @(posedge clk);
        #1;
        if (seq_w_wrap === 1'b1) wraps++;
        check_val("wrap_count", 32'(wraps), 32'd1);
        check_val("wrap_after_write", 32'(wrap_at), 32'(DP - 1));
        check_val("wrap_land_addr0", 32'(ran_r_data), 32'h48);
        @(negedge clk);
        ran_r_addr = 4'd1;
        @(posedge clk);
        #1;
        check_val("wrap_land_addr1", 32'(ran_r_data), 32'h49);
        check_val("wrap_land_valid", 32'(ran_r_valid), 32'd1);

        @(negedge clk);
        drive(idle);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/banked_regfile.md
BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words; legal range 2..2^ADDR_WIDTH.
REQ-004 SHALL use one clock, clk; reset is synchronous and active-high, port rst.
REQ-005 Ports, in order: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- seq_we  in  1  sequential write enable.
- seq_w_data  in  DATA_WIDTH  sequential write data.
- seq_w_clr  in  1  return the sequential write pointer to 0.
- ran_we  in  1  random write enable.
- ran_w_addr  in  ADDR_WIDTH  random write address.
- ran_w_data  in  DATA_WIDTH  random write data.
- seq_re  in  1  sequential read enable.
- seq_r_clr  in  1  return the sequential read pointer to 0.
- seq_r_data  out  DATA_WIDTH  sequential read data.
- seq_r_valid  out  1  seq_r_data valid this cycle.
- out_seq_r_addr  out  ADDR_WIDTH  address of seq_r_data.
- ran_re  in  1  random read enable.
- ran_r_addr  in  ADDR_WIDTH  random read address.
- ran_r_data  out  DATA_WIDTH  random read data.
- ran_r_valid  out  1  ran_r_data valid this cycle.
- out_ran_r_addr  out  ADDR_WIDTH  address of ran_r_data.
- seq_w_wrap  out  1  one-cycle pulse: write pointer wrapped.
- seq_r_wrap  out  1  one-cycle pulse: read pointer wrapped.
- wr_collision  out  1  one-cycle pulse: both write ports hit the same address.
- addr_err  out  1  one-cycle pulse: random access to an address >= DEPTH.

Function
REQ-006 seq_we SHALL write seq_w_data at the write pointer; the pointer then increments, DEPTH-1 -> 0, and seq_w_wrap pulses the following cycle.
REQ-007 seq_w_clr SHALL set the write pointer to 0; with seq_we in the same cycle the word is written at 0 and the pointer becomes 1.
REQ-008 ran_we SHALL write ran_w_data at ran_w_addr; an address >= DEPTH SHALL write nothing and pulse addr_err the next cycle.
REQ-009 Both ports writing one address in one cycle: the random write SHALL win, wr_collision pulses the next cycle, and the sequential pointer still advances.
REQ-010 seq_re SHALL give, one cycle later, seq_r_data = mem[read pointer], seq_r_valid=1 and out_seq_r_addr = that pointer; the pointer increments and wraps like the write pointer, with seq_r_wrap pulsing.
REQ-011 seq_r_clr SHALL behave as in REQ-007 for the read pointer.
REQ-012 ran_re SHALL give, one cycle later, ran_r_data, ran_r_valid=1 and out_ran_r_addr = ran_r_addr; an address >= DEPTH SHALL leave ran_r_valid=0 and pulse addr_err.
REQ-013 Both read ports SHALL run independently in the same cycle; each has a latency of exactly 1 cycle.
REQ-014 With valid=0, the data and addr outputs SHALL hold their last values.
REQ-015 A read of an address written in the same cycle SHALL return the old contents unless REQ-019 applies.

Reset
REQ-016 While rst=1: both pointers 0, all outputs 0, and all writes and reads that cycle are suppressed.
REQ-017 Reset SHALL NOT clear the memory contents.

Configuration
REQ-018 Macro REGFILE_RDW_BYPASS_EN SHALL select read-during-write behaviour.
REQ-019 With REGFILE_RDW_BYPASS_EN defined, a read of an address written in the same cycle SHALL return the new data; on a collision this is the random-write data.
REQ-020 With REGFILE_RDW_BYPASS_EN undefined, REQ-015 SHALL apply and no bypass logic is present.

Verification
REQ-021 rst 1->0, seq_we for 3 cycles with F3, 98, 3F; seq_re for 3 cycles -> seq_r_data F3, 98, 3F at out_seq_r_addr 0, 1, 2, each with seq_r_valid=1.
REQ-022 DEPTH=4, 5 seq writes -> seq_w_wrap pulses once after the 4th write; the 5th write lands at address 0.
REQ-023 seq_we=1 with pointer 5, and ran_we=1 with addr 5 and data A0 -> mem[5]=A0 and wr_collision pulses once.
REQ-024 ran_re addr 6 while ran_we writes A1 to 6 -> ran_r_data is old data without the macro, A1 with REGFILE_RDW_BYPASS_EN.
REQ-025 DEPTH=4, ran_re addr 9 -> ran_r_valid=0 and addr_err pulses; rst asserted during seq_we -> no write, pointers 0.
